// File: rtl/read_addr_scheduler.sv
// Read-address scheduler: arbitrates two AXI read masters onto one slave AR
// channel, keeps a single read outstanding, tracks the R burst and flags
// burst-length mismatches.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module read_addr_scheduler #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [2:0]                ARSIZE_M0,
    input  logic [2:0]                ARSIZE_M1,
    input  logic [1:0]                ARBURST_M0,
    input  logic [1:0]                ARBURST_M1,
    input  logic                      ARVALID_M0,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M0,
    output logic                      ARREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]  ARID_S,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_S,
    output logic [2:0]                ARSIZE_S,
    output logic [1:0]                ARBURST_S,
    output logic                      ARVALID_S,
    input  logic                      ARREADY_S,
    input  logic                      RVALID_S,
    input  logic                      RREADY_S,
    input  logic                      RLAST_S,
    output logic                      M0_flag,
    output logic                      M1_flag,
    output logic                      LEN_ERR
);

    localparam int ID_W  = `AXI_ID_BITS;
    localparam int LEN_W = `AXI_LEN_BITS;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             len_err_d;
    logic             owner_valid;
    logic             ar_hs;
    logic             r_beat;

    // Next-state logic: arbitration in IDLE, handshake tracking in ADDR, beat counting in DATA.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        len_err_d   = 1'b0;
        owner_valid = owner_q ? ARVALID_M1 : ARVALID_M0;
        ar_hs       = (state_q == ADDR) && owner_valid && ARREADY_S;
        r_beat      = RVALID_S && RREADY_S;
        case (state_q)
            IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    state_d = ADDR;
                    if (ARVALID_M0 && ARVALID_M1) begin
                        owner_d = rr_ptr_q;
                    end else begin
                        owner_d = ARVALID_M1;
                    end
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d    = DATA;
                    beat_cnt_d = owner_q ? ARLEN_M1 : ARLEN_M0;
                    rr_ptr_d   = ~owner_q;
                end else if (!owner_valid) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (r_beat) begin
                    if (RLAST_S) begin
                        state_d    = IDLE;
                        len_err_d  = (beat_cnt_q != '0);
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side AR mux and per-master ready, live only while an address is being offered.
    always_comb begin
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        if (state_q == ADDR) begin
            if (owner_q) begin
                ARID_S     = {ARID_M1, {ID_W{1'b0}}};
                ARADDR_S   = ARADDR_M1;
                ARLEN_S    = ARLEN_M1;
                ARSIZE_S   = ARSIZE_M1;
                ARBURST_S  = ARBURST_M1;
                ARVALID_S  = ARVALID_M1;
                ARREADY_M1 = ARREADY_S;
            end else begin
                ARID_S     = {{ID_W{1'b0}}, ARID_M0};
                ARADDR_S   = ARADDR_M0;
                ARLEN_S    = ARLEN_M0;
                ARSIZE_S   = ARSIZE_M0;
                ARBURST_S  = ARBURST_M0;
                ARVALID_S  = ARVALID_M0;
                ARREADY_M0 = ARREADY_S;
            end
        end
    end

    // State register; flags are derived from the next state so they line up with the state itself.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= RR_INIT;
            beat_cnt_q <= '0;
            LEN_ERR    <= 1'b0;
            M0_flag    <= 1'b0;
            M1_flag    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            LEN_ERR    <= len_err_d;
            M0_flag    <= (state_d != IDLE) && !owner_d;
            M1_flag    <= (state_d != IDLE) && owner_d;
        end
    end

endmodule

// File: tb/tb_read_addr_scheduler.sv
// Testbench for read_addr_scheduler: table of read scenarios plus a few
// hand-written multi-cycle sequences, with a scoreboard on the AR handshake.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module tb_read_addr_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic        RVALID_S, RREADY_S, RLAST_S;
    logic        M0_flag, M1_flag, LEN_ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        own;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [1:0] req;
        logic [3:0] len;
        int         beats;
        int         delay;
        logic       own;
        logic       err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    read_addr_scheduler #(.RR_INIT(1'b0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
        .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
        .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
        .ARREADY_S(ARREADY_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
        .M0_flag(M0_flag), .M1_flag(M1_flag), .LEN_ERR(LEN_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] req, input logic [3:0] len, input int idx);
        ARID_M0    = 4'(idx + 1);
        ARID_M1    = 4'(idx + 9);
        ARADDR_M0  = 32'h1000_0000 + (32'(idx) << 4);
        ARADDR_M1  = 32'h2000_0000 + (32'(idx) << 4);
        ARLEN_M0   = len;
        ARLEN_M1   = len;
        ARSIZE_M0  = 3'd2;
        ARSIZE_M1  = 3'd3;
        ARBURST_M0 = 2'b01;
        ARBURST_M1 = 2'b10;
        ARVALID_M0 = req[0];
        ARVALID_M1 = req[1];
    endtask

    task automatic push_expect(input logic own);
        exp_t e;
        e.own   = own;
        e.id    = own ? {ARID_M1, 4'h0} : {4'h0, ARID_M0};
        e.addr  = own ? ARADDR_M1 : ARADDR_M0;
        e.len   = own ? ARLEN_M1 : ARLEN_M0;
        e.size  = own ? ARSIZE_M1 : ARSIZE_M0;
        e.burst = own ? ARBURST_M1 : ARBURST_M0;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
        RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;
        tick();
    endtask

    // Called in the first ADDR cycle; stalls the slave for 'delay' cycles then accepts.
    task automatic handshake(input logic own, input int delay);
        for (int c = 0; c < delay; c++) begin
            check_output("stall_arvalid_s", 32'(ARVALID_S), 32'd1);
            check_output("stall_arready_m0", 32'(ARREADY_M0), 32'd0);
            check_output("stall_arready_m1", 32'(ARREADY_M1), 32'd0);
            check_output("stall_owner_flag", 32'(own ? M1_flag : M0_flag), 32'd1);
            tick();
        end
        ARREADY_S = 1'b1;
        #1;
        check_output("hs_arready_m0", 32'(ARREADY_M0), 32'(!own));
        check_output("hs_arready_m1", 32'(ARREADY_M1), 32'(own));
        tick();
        ARREADY_S = 1'b0;
    endtask

    task automatic beat(input logic last);
        RVALID_S = 1'b1;
        RREADY_S = 1'b1;
        RLAST_S  = last;
        tick();
        RVALID_S = 1'b0;
        RREADY_S = 1'b0;
        RLAST_S  = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic exp_err, input logic own);
        for (int b = 1; b <= n; b++) begin
            beat(b == n);
            if (b < n) begin
                check_output("mid_len_err", 32'(LEN_ERR), 32'd0);
                check_output("mid_owner_flag", 32'(own ? M1_flag : M0_flag), 32'd1);
                check_output("data_no_ar", 32'(ARVALID_S), 32'd0);
            end else begin
                check_output("last_len_err", 32'(LEN_ERR), 32'(exp_err));
                check_output("last_flags", 32'({M1_flag, M0_flag}), 32'd0);
            end
        end
    endtask

    // Scoreboard: every AR handshake must match the oldest expected request.
    always @(negedge ACLK) begin : monitor
        exp_t e;
        if (!ARESET && ARVALID_S && ARREADY_S) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: got handshake ARID_S=0x%0h, expected none at %0t", ARID_S, $time);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_arid", 32'(ARID_S), 32'(e.id));
                check_output("sb_araddr", ARADDR_S, e.addr);
                check_output("sb_arlen", 32'(ARLEN_S), 32'(e.len));
                check_output("sb_arsize", 32'(ARSIZE_S), 32'(e.size));
                check_output("sb_arburst", 32'(ARBURST_S), 32'(e.burst));
                check_output("sb_flags", 32'({M1_flag, M0_flag}), e.own ? 32'd2 : 32'd1);
            end
        end
        check_output("flags_exclusive", 32'(M0_flag & M1_flag), 32'd0);
    end

    initial begin
        vecs[0] = '{2'b01, 4'd3,  4,  0, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 4'd1,  1,  0, 1'b1, 1'b1};
        vecs[2] = '{2'b11, 4'd2,  3,  5, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 4'd0,  1,  1, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 4'd7,  8,  2, 1'b1, 1'b0};
        vecs[5] = '{2'b11, 4'd4,  2,  0, 1'b0, 1'b1};
        vecs[6] = '{2'b01, 4'd15, 16, 0, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 4'd5,  6,  0, 1'b1, 1'b0};

        apply_stimulus(2'b11, 4'd3, 0);
        ARESET = 1'b1; ARREADY_S = 1'b1;
        RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        repeat (3) tick();
        check_output("rst_arvalid_s", 32'(ARVALID_S), 32'd0);
        check_output("rst_arid_s", 32'(ARID_S), 32'd0);
        check_output("rst_araddr_s", ARADDR_S, 32'd0);
        check_output("rst_arready_m", 32'({ARREADY_M1, ARREADY_M0}), 32'd0);
        check_output("rst_flags", 32'({M1_flag, M0_flag}), 32'd0);
        check_output("rst_len_err", 32'(LEN_ERR), 32'd0);
        ARESET = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
        tick();
        check_output("idle_flags", 32'({M1_flag, M0_flag}), 32'd0);

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].len, i);
            push_expect(vecs[i].own);
            tick();
            check_output("arb_latency", 32'(ARVALID_S), 32'd1);
            handshake(vecs[i].own, vecs[i].delay);
            ARVALID_M0 = 1'b0;
            ARVALID_M1 = 1'b0;
            send_beats(vecs[i].beats, vecs[i].err, vecs[i].own);
            tick();
            check_output("len_err_one_cycle", 32'(LEN_ERR), 32'd0);
        end

        // Tie after reset goes to M0, then to M1 while M0 keeps requesting.
        do_reset();
        apply_stimulus(2'b11, 4'd0, 20);
        push_expect(1'b0);
        tick();
        handshake(1'b0, 0);
        check_output("data_no_ar_tie", 32'(ARVALID_S), 32'd0);
        check_output("data_no_ready_m1", 32'(ARREADY_M1), 32'd0);
        send_beats(1, 1'b0, 1'b0);
        check_output("post_rlast_idle", 32'(ARVALID_S), 32'd0);
        push_expect(1'b1);
        tick();
        check_output("regrant_m1", 32'(ARVALID_S), 32'd1);
        handshake(1'b1, 0);
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;
        send_beats(1, 1'b0, 1'b1);
        tick();

        // Requester withdraws in ADDR: back to IDLE, pointer untouched.
        do_reset();
        apply_stimulus(2'b01, 4'd3, 30);
        tick();
        check_output("abort_arvalid_s", 32'(ARVALID_S), 32'd1);
        check_output("abort_flag", 32'(M0_flag), 32'd1);
        ARVALID_M0 = 1'b0;
        #1;
        check_output("abort_drop", 32'(ARVALID_S), 32'd0);
        tick();
        check_output("abort_idle_flags", 32'({M1_flag, M0_flag}), 32'd0);
        apply_stimulus(2'b11, 4'd3, 31);
        push_expect(1'b0);
        tick();
        handshake(1'b0, 0);
        ARVALID_M0 = 1'b0;
        ARVALID_M1 = 1'b0;

        // Reset mid-burst, with an offending RLAST beat on the reset edge.
        beat(1'b0);
        beat(1'b0);
        ARESET = 1'b1;
        RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
        tick();
        check_output("rst_data_flags", 32'({M1_flag, M0_flag}), 32'd0);
        check_output("rst_data_len_err", 32'(LEN_ERR), 32'd0);
        ARESET = 1'b0;
        RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        tick();
        check_output("post_rst_len_err", 32'(LEN_ERR), 32'd0);
        apply_stimulus(2'b10, 4'd0, 32);
        push_expect(1'b1);
        tick();
        check_output("post_rst_grant", 32'(ARVALID_S), 32'd1);
        handshake(1'b1, 0);
        ARVALID_M1 = 1'b0;
        send_beats(1, 1'b0, 1'b1);
        tick();

        // Too many beats: error on the extra beat, FSM stays in DATA.
        apply_stimulus(2'b01, 4'd1, 40);
        push_expect(1'b0);
        tick();
        handshake(1'b0, 0);
        ARVALID_M0 = 1'b0;
        beat(1'b0);
        check_output("ovf_beat1_err", 32'(LEN_ERR), 32'd0);
        beat(1'b0);
        check_output("ovf_beat2_err", 32'(LEN_ERR), 32'd1);
        check_output("ovf_stay_data", 32'(M0_flag), 32'd1);
        tick();
        check_output("ovf_pulse_end", 32'(LEN_ERR), 32'd0);
        check_output("ovf_still_data", 32'(M0_flag), 32'd1);
        beat(1'b1);
        check_output("ovf_last_err", 32'(LEN_ERR), 32'd0);
        check_output("ovf_idle", 32'({M1_flag, M0_flag}), 32'd0);
        tick();

        check_output("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/read_addr_scheduler.md
READ_ADDR_SCHEDULER -- requirements
Module: read_addr_scheduler

Interface
REQ-001 Parameter RR_INIT, default 0, selects the master favoured after reset (0 = M0, 1 = M1).
REQ-002 Port ACLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port ARESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port pair ARID_M0 / ARID_M1, input, `AXI_ID_BITS each: per-master read ID.
REQ-005 Port pair ARADDR_M0 / ARADDR_M1, input, `AXI_ADDR_BITS each: per-master read address.
REQ-006 Port pair ARLEN_M0 / ARLEN_M1, input, `AXI_LEN_BITS each: per-master burst length minus 1.
REQ-007 Port pairs ARSIZE_Mx (3 bits) and ARBURST_Mx (2 bits), input: per-master burst attributes.
REQ-008 Port pair ARVALID_M0 / ARVALID_M1, input, 1 bit each: per-master request valid.
REQ-009 Port pair ARREADY_M0 / ARREADY_M1, output, 1 bit each: per-master address accept.
REQ-010 Ports ARID_S (`AXI_IDS_BITS), ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, output: shared slave-side AR channel.
REQ-011 Port ARREADY_S, input, 1 bit: slave address accept.
REQ-012 Ports RVALID_S, RREADY_S, RLAST_S, input, 1 bit each: shared R-channel handshake, observed only.
REQ-013 Ports M0_flag / M1_flag, output, 1 bit each: R-channel owner, consumed by the read-data router.
REQ-014 Port LEN_ERR, output, 1 bit: one-cycle pulse on a burst-length mismatch.

Function
REQ-015 The block SHALL implement FSM states IDLE, ADDR and DATA.
REQ-016 IDLE: if any ARVALID_Mx is high, the block SHALL latch the owner and go to ADDR next cycle.
REQ-017 Owner choice: a single requester wins; on a tie the master not granted last wins (round-robin pointer).
REQ-018 The round-robin pointer SHALL update only on the AR handshake.
REQ-019 ADDR: the slave-side AR outputs SHALL mux from the owner's inputs, with ARVALID_S = owner's ARVALID.
REQ-020 ADDR: ARREADY_owner SHALL equal ARREADY_S, and the non-owner's ARREADY SHALL be 0.
REQ-021 ADDR: if the owner's ARVALID drops before the handshake, the block SHALL return to IDLE without completing the handshake.
REQ-022 ARID_S SHALL be {4'b0, ARID_M0} for owner M0 and {ARID_M1, 4'b0} for owner M1.
REQ-023 On the AR handshake (ARVALID_S & ARREADY_S), the block SHALL capture ARLEN into a beat counter and go to DATA.
REQ-024 DATA: each RVALID_S & RREADY_S beat SHALL decrement the counter.
REQ-025 DATA: a beat carrying RLAST_S SHALL return the FSM to IDLE next cycle.
REQ-026 DATA: no new AR SHALL be issued (single outstanding read).
REQ-027 LEN_ERR SHALL pulse for one cycle, the cycle after the offending beat, when RLAST_S arrives with counter != 0.
REQ-028 LEN_ERR SHALL also pulse, the cycle after the offending beat, when a beat arrives with counter == 0 and RLAST_S low; the FSM SHALL then stay in DATA.
REQ-029 Mx_flag SHALL be a registered output, high exactly while state is ADDR or DATA with owner Mx, and the flags SHALL never both be high.
REQ-030 Outside ADDR, all slave-side AR outputs and both ARREADY_Mx SHALL be 0.
REQ-031 Arbitration latency SHALL be 1 cycle: ARVALID seen in IDLE gives ARVALID_S in the next cycle.
REQ-032 After RLAST, a new request SHALL be granted at earliest 2 cycles later (DATA -> IDLE -> ADDR).

Reset
REQ-033 While ARESET is high at a clock edge, the block SHALL enter state IDLE.
REQ-034 While ARESET is high at a clock edge, pointer = RR_INIT, beat counter = 0, M0_flag = M1_flag = 0 and LEN_ERR = 0.
REQ-035 During reset, all AR outputs and ARREADY_Mx SHALL be 0.
REQ-036 Reset asserted mid-ADDR or mid-DATA SHALL abort the transfer in the same edge, with no LEN_ERR.

Verification
REQ-037 Single M0 read, ARLEN=3, ARREADY_S immediate, 4 beats with RLAST on beat 4 -> ARID_S=0x0?, M0_flag high from ADDR through last beat, IDLE after, LEN_ERR=0.
REQ-038 M0 and M1 both valid after reset (RR_INIT=0) -> M0 granted first; M1 granted on the next arbitration while M0 re-requests; ARID_S=0x?0 for M1.
REQ-039 M1 ARLEN=1, RLAST asserted on beat 1 -> LEN_ERR pulses once, FSM returns to IDLE.
REQ-040 ARREADY_S held low 5 cycles -> ARVALID_S held stable, ARREADY_M0 stays 0, handshake on cycle 6.
REQ-041 ARESET pulsed in DATA mid-burst -> flags low and FSM in IDLE next cycle; next request arbitrated normally.
